// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit.
// Operation codes and widths used by the slice and the pipeline top.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
  localparam logic [OP_W-1:0] OP_ORN  = 3'd7;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operation slice: per-bit gates plus op select.
// Sits between the operand stage and the result stage.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] g_and;
  logic [WIDTH-1:0] g_or;
  logic [WIDTH-1:0] g_xor;
  logic [WIDTH-1:0] g_nor;
  logic [WIDTH-1:0] g_nand;
  logic [WIDTH-1:0] g_xnor;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] g_andn;
  logic [WIDTH-1:0] g_orn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and  u_and  (g_and[i],  a[i], b[i]);
    or   u_or   (g_or[i],   a[i], b[i]);
    xor  u_xor  (g_xor[i],  a[i], b[i]);
    nor  u_nor  (g_nor[i],  a[i], b[i]);
    nand u_nand (g_nand[i], a[i], b[i]);
    xnor u_xnor (g_xnor[i], a[i], b[i]);
    not  u_not  (nb[i],     b[i]);
    and  u_andn (g_andn[i], a[i], nb[i]);
    or   u_orn  (g_orn[i],  a[i], nb[i]);
  end

  always_comb begin
    result = g_and;
    case (op)
      OP_AND:  result = g_and;
      OP_OR:   result = g_or;
      OP_XOR:  result = g_xor;
      OP_NOR:  result = g_nor;
      OP_NAND: result = g_nand;
      OP_XNOR: result = g_xnor;
      OP_ANDN: result = g_andn;
      OP_ORN:  result = g_orn;
      default: result = g_and;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready on both sides.
// Optional operand stage feeds the slice; result stage holds word and flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit REG_IN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             all_ones
);

  logic             out_free;
  logic             src_valid;
  logic [OP_W-1:0]  src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] res_c;

  assign out_free = !out_valid || out_ready;

  if (REG_IN) begin : g_s1
    logic             s1_valid;
    logic             s1_advance;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    assign s1_advance = s1_valid && out_free;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid <= 1'b0;
        s1_op    <= '0;
        s1_a     <= '0;
        s1_b     <= '0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op;
          s1_a  <= a;
          s1_b  <= b;
        end
      end
    end

    assign src_valid = s1_valid;
    assign src_op    = s1_op;
    assign src_a     = s1_a;
    assign src_b     = s1_b;
  end else begin : g_bypass
    assign in_ready  = out_free;
    assign src_valid = in_valid;
    assign src_op    = op;
    assign src_a     = a;
    assign src_b     = b;
  end

  logic_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .op     (src_op),
    .a      (src_a),
    .b      (src_b),
    .result (res_c)
  );

  // flags derive from the same word that lands in the result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      all_ones  <= 1'b0;
    end else if (out_free) begin
      out_valid <= src_valid;
      if (src_valid) begin
        result   <= res_c;
        zero     <= ~|res_c;
        all_ones <= &res_c;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: WIDTH=32/REG_IN=1 and WIDTH=1/REG_IN=0 side by side.
// Queue-based reference model plus literal expectations for known vectors.
module tb_logic_unit_pipe;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } item_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ao;
  } cap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        ir0, ov0, z0, ao0;
  logic [31:0] r0;
  logic        ir1, ov1, z1, ao1;
  logic [0:0]  r1;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .REG_IN(1'b1)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (ov0),
    .out_ready (out_ready),
    .result    (r0),
    .zero      (z0),
    .all_ones  (ao0)
  );

  logic_unit_pipe #(.WIDTH(1), .REG_IN(1'b0)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (ir1),
    .op        (op),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .out_valid (ov1),
    .out_ready (out_ready),
    .result    (r1),
    .zero      (z1),
    .all_ones  (ao1)
  );

  logic [31:0] res_d [2];
  logic        ov_d  [2];
  logic        ir_d  [2];
  logic        z_d   [2];
  logic        ao_d  [2];

  assign res_d[0] = r0;
  assign res_d[1] = {31'b0, r1};
  assign ov_d[0]  = ov0;
  assign ov_d[1]  = ov1;
  assign ir_d[0]  = ir0;
  assign ir_d[1]  = ir1;
  assign z_d[0]   = z0;
  assign z_d[1]   = z1;
  assign ao_d[0]  = ao0;
  assign ao_d[1]  = ao1;

  int lat [2] = '{2, 1};
  int wid [2] = '{32, 1};

  item_t q   [2][$];
  cap_t  cap [2][$];
  int    n_acc  [2] = '{0, 0};
  logic  last_in  [2];
  logic  last_out [2];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  localparam logic [31:0] TA = 32'hF0F0_00FF;
  localparam logic [31:0] TB = 32'h0FF0_0F0F;
  logic [31:0] exp_ops [8] = '{
    32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000,
    32'hFF0F_FFF0, 32'h00FF_F00F, 32'hF000_00F0, 32'hF0FF_F0FF
  };

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input int w);
    logic [31:0] m;
    logic [31:0] r;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x | y);
      3'd4:    r = ~(x & y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      default: r = x | ~y;
    endcase
    return r & m;
  endfunction

  // one clock cycle: check held outputs, drive inputs, check ready, update model
  task automatic step(input logic iv, input logic [2:0] o,
                      input logic [31:0] aa, input logic [31:0] bb,
                      input logic ordy);
    int   nq [2];
    logic ev;
    logic [31:0] m;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nq[d] = q[d].size();
      ev = (nq[d] > 0) && (cyc - q[d][0].acc >= lat[d] - 1);
      chk($sformatf("d%0d.out_valid", d), {31'b0, ov_d[d]}, {31'b0, ev});
      if (ev) begin
        m = (wid[d] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[d]) - 32'd1);
        chk($sformatf("d%0d.result", d), res_d[d], q[d][0].res);
        chk($sformatf("d%0d.zero", d), {31'b0, z_d[d]},
            {31'b0, q[d][0].res == 32'd0});
        chk($sformatf("d%0d.all_ones", d), {31'b0, ao_d[d]},
            {31'b0, q[d][0].res == m});
      end
    end
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      ev = (lat[d] == 2) ? (nq[d] < 2 || ordy) : (nq[d] == 0 || ordy);
      chk($sformatf("d%0d.in_ready", d), {31'b0, ir_d[d]}, {31'b0, ev});
      last_out[d] = ov_d[d] && ordy;
      last_in[d]  = iv && ir_d[d];
      if (last_out[d]) begin
        cap[d].push_back('{res_d[d], z_d[d], ao_d[d]});
        if (q[d].size() > 0) void'(q[d].pop_front());
      end
      if (last_in[d]) begin
        q[d].push_back('{ref_op(o, aa, bb, wid[d]), cyc + 1});
        n_acc[d]++;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic clear_caps;
    cap[0].delete();
    cap[1].delete();
  endtask

  initial begin
    int k;
    int c;
    int stall_acc;
    int base;

    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 32'd0;
    b         = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", {31'b0, ov0}, 32'd0);
    chk("rst.result", r0, 32'd0);
    chk("rst.flags", {30'b0, z0, ao0}, 32'd0);
    chk("rst.in_ready", {31'b0, ir0}, 32'd1);
    reset = 1'b0;

    // operation table, back-to-back, latency 2
    clear_caps();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), TA, TB, 1'b1);
    drain(4);
    chk("ops.count", cap[0].size(), 32'd8);
    for (int i = 0; i < 8 && i < cap[0].size(); i++)
      chk($sformatf("ops.op%0d", i), cap[0][i].res, exp_ops[i]);

    // flag extremes
    clear_caps();
    step(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    drain(3);
    if (cap[0].size() == 2) begin
      chk("flags.and", {cap[0][0].res[0], cap[0][0].z, cap[0][0].ao},
          {29'b0, 3'b010});
      chk("flags.or", {cap[0][1].res[0], cap[0][1].z, cap[0][1].ao},
          {29'b0, 3'b101});
    end else begin
      chk("flags.count", cap[0].size(), 32'd2);
    end

    // backpressure then simultaneous drain/accept
    clear_caps();
    k = 0;
    c = 0;
    stall_acc = 0;
    while (k < 4 && c < 40) begin
      step(1'b1, 3'(k), TA, TB, c >= 5);
      if (last_in[0]) begin
        if (c < 5) stall_acc++;
        k++;
      end
      if (c == 5)
        chk("simul.in_out", {30'b0, last_in[0], last_out[0]}, 32'd3);
      c++;
    end
    chk("bp.all_sent", k, 32'd4);
    chk("bp.stall_acc", stall_acc, 32'd2);
    drain(6);
    chk("bp.count", cap[0].size(), 32'd4);
    for (int i = 0; i < 4 && i < cap[0].size(); i++)
      chk($sformatf("bp.item%0d", i), cap[0][i].res, exp_ops[i]);

    // reset with two items in flight
    step(1'b1, 3'd1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    step(1'b1, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst.out_valid", {31'b0, ov0}, 32'd0);
    chk("mid_rst.result", r0, 32'd0);
    chk("mid_rst.in_ready", {31'b0, ir0}, 32'd1);
    chk("mid_rst.d1", {28'b0, ov1, r1, z1, ao1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    q[0].delete();
    q[1].delete();
    drain(4);

    // single-bit unit, bypassed input stage: XNOR(1,0)
    clear_caps();
    step(1'b1, 3'd5, 32'd1, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("w1.lat1_valid", {30'b0, ov1, ov0}, 32'd2);
    chk("w1.xnor", {29'b0, r1, z1, ao1}, 32'd2);
    drain(3);

    // randomized traffic
    base = n_acc[1];
    for (int i = 0; i < 60000 && n_acc[1] - base < 10000; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           $urandom, $urandom, $urandom_range(0, 3) != 0);
    chk("rand.txns", {31'b0, (n_acc[1] - base) >= 10000}, 32'd1);
    drain(4);
    chk("end.q0_empty", q[0].size(), 32'd0);
    chk("end.q1_empty", q[1].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
